ssd_decode: RTL and testbench
=============================

# ssd_decode

Seven-segment bus receiver for the stacker score path: samples the `ssd`/`ssdcat` display lines driven by the score encoder and recovers the displayed 8-bit score. It filters transient patterns with a stability counter and maps each accepted segment pattern back to its hex nibble. It assembles a low/high digit pair into one score word, with a one-cycle `valid` strobe and an `err` strobe for patterns that are not in the table. Used for score readback and self-check of the display path.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted; legal range 2..255.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `ssd`  input  7  segment lines {a,b,c,d,e,f,g}, active-high.
- `ssdcat`  input  1  digit select: 0 = low digit, 1 = high digit.
- `value`  output  8  last assembled score {hi,lo}; holds between frames.
- `valid`  output  1  one-cycle pulse when `value` is updated.
- `err`  output  1  one-cycle pulse when an accepted pattern is not decodable.

## Operation
- Input register `s_q` captures {ssdcat, ssd} every cycle.
- Stability counter `cnt`, 8 bits, saturating:
  - `cnt` = 0 after reset.
  - `cnt` loads 1 when the new sample differs from `s_q`, or when `cnt` = 0.
  - Otherwise `cnt` increments until it reaches `STABLE_CYCLES`, then holds.
- Accept event: fires on the edge where `cnt` reaches `STABLE_CYCLES`. It fires exactly once per stable run; there is no re-accept until the pattern changes.
- Decode table for ssd[6:0]:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=73, A=77, B=1F, C=4E, D=3D, E=4F, F=47
  - Any other pattern is undecodable.
- FSM states: IDLE, HAVE_LO.
  - IDLE + accept, ssdcat=0, decodable: latch `lo`, go to HAVE_LO.
  - IDLE + accept, ssdcat=1: ignore (no `lo` yet); no `err` unless the pattern is undecodable.
  - HAVE_LO + accept, ssdcat=0, decodable: overwrite `lo`, stay in HAVE_LO.
  - HAVE_LO + accept, ssdcat=1, decodable: `value` <= {hi, lo}, pulse `valid`, go to IDLE.
  - Any accept with an undecodable pattern: pulse `err`, go to IDLE, leave `lo` and `value` unchanged.
- `valid` and `err` are never asserted in the same cycle.

## Timing
- Reset values:
  - `value` = 8'h00, `valid` = 0, `err` = 0.
  - `s_q` = 8'h00, `cnt` = 0, `lo` = 0, FSM = IDLE.
- Reset asserted mid-frame: all state returns to reset values immediately; any partial pair is discarded.
- Latency: a pattern first sampled into `s_q` at edge k produces the accept at edge k+STABLE_CYCLES-1. The `valid`/`err` pulse is registered and visible for the one cycle after edge k+STABLE_CYCLES.
- A change in the input at any point before accept restarts the count. Glitches shorter than `STABLE_CYCLES` samples are never decoded.
- A change of `ssdcat` alone (same segments) counts as a new pattern.

## Configuration
- `SSD_DECODE_BLANK_EN` defined: pattern 7'h00 (blank digit) is decodable as nibble 0, so a leading-blank high digit yields a valid score.
- Not defined: 7'h00 is undecodable and its accept pulses `err`.

## Test plan
- Reset, then drive ssdcat=0/ssd=7'h5B for 4 cycles, then ssdcat=1/ssd=7'h30 for 4 cycles -> single `valid` pulse with `value` = 8'h15; `err` stays 0.
- Low digit 7'h7F held only 3 cycles, then ssdcat=0/7'h79 for 4 cycles, then ssdcat=1/7'h47 for 4 cycles -> `value` = 8'hF3; the 3-cycle pattern is never accepted.
- Accept lo=7'h33, then ssdcat=1/ssd=7'h01 for 4 cycles -> `err` pulse, no `valid`, `value` unchanged, FSM back in IDLE.
- Hold ssdcat=1/7'h6D for 20 cycles from IDLE -> no `valid` and no `err`. Then lo=7'h70 followed by hi=7'h6D -> `value` = 8'h27, exactly one `valid`.
- Assert `rst_n` low for 1 cycle while in HAVE_LO with lo=9, then send hi=7'h30 -> no `valid` (pair discarded), and `value` reads 8'h00.
- Blank high digit (7'h00) after lo=7'h4E -> with `SSD_DECODE_BLANK_EN`, `value` = 8'h0C with `valid`; without it, `err` pulse and no `valid`.

Source files
------------

// File: rtl/ssd_decode.sv
// rtl/ssd_decode.sv - seven-segment display-line receiver recovering an 8-bit score (optional: SSD_DECODE_BLANK_EN)
module ssd_decode #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] ssd,
    input  logic       ssdcat,
    output logic [7:0] value,
    output logic       valid,
    output logic       err
);

    typedef enum logic {
        IDLE    = 1'b0,
        HAVE_LO = 1'b1
    } state_t;

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

    logic [7:0] r_s_q;
    logic [7:0] r_cnt;
    logic       r_acc;
    logic [7:0] r_acc_pat;
    logic [3:0] r_lo;
    state_t     r_state;

    logic [7:0] w_sample;
    logic       w_same;
    logic [7:0] w_cnt_nxt;
    logic       w_accept;
    logic       w_dec_ok;
    logic [3:0] w_dec_nib;
    logic       w_cat;
    state_t     w_state_nxt;
    logic       w_lo_load;
    logic       w_value_load;
    logic       w_err_nxt;

    assign w_sample = {ssdcat, ssd};
    assign w_same   = (w_sample == r_s_q);
    // Accept on the edge where the count climbs to the threshold; holding at the
    // threshold afterwards keeps it from firing again on the same run.
    assign w_accept = w_same && (r_cnt != 8'd0) && (r_cnt == LP_STABLE - 8'd1);
    assign w_cat    = r_acc_pat[7];

    // Stability counter next value: restart on change or from the cleared state, saturate at threshold
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!w_same || r_cnt == 8'd0)
            w_cnt_nxt = 8'd1;
        else if (r_cnt < LP_STABLE)
            w_cnt_nxt = r_cnt + 8'd1;
    end

    // Sample register, stability counter and the registered accept event with its pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q     <= 8'h00;
            r_cnt     <= 8'd0;
            r_acc     <= 1'b0;
            r_acc_pat <= 8'h00;
        end else begin
            r_s_q     <= w_sample;
            r_cnt     <= w_cnt_nxt;
            r_acc     <= w_accept;
            r_acc_pat <= w_sample;
        end
    end

    // Map the accepted segment pattern back to its hex nibble
    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_nib = 4'h0;
        case (r_acc_pat[6:0])
            7'h7E: w_dec_nib = 4'h0;
            7'h30: w_dec_nib = 4'h1;
            7'h6D: w_dec_nib = 4'h2;
            7'h79: w_dec_nib = 4'h3;
            7'h33: w_dec_nib = 4'h4;
            7'h5B: w_dec_nib = 4'h5;
            7'h5F: w_dec_nib = 4'h6;
            7'h70: w_dec_nib = 4'h7;
            7'h7F: w_dec_nib = 4'h8;
            7'h73: w_dec_nib = 4'h9;
            7'h77: w_dec_nib = 4'hA;
            7'h1F: w_dec_nib = 4'hB;
            7'h4E: w_dec_nib = 4'hC;
            7'h3D: w_dec_nib = 4'hD;
            7'h4F: w_dec_nib = 4'hE;
            7'h47: w_dec_nib = 4'hF;
`ifdef SSD_DECODE_BLANK_EN
            7'h00: w_dec_nib = 4'h0;
`endif
            default: w_dec_ok = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state: a low digit arms the pair, a high digit or a bad pattern closes it
    always_comb begin
        w_state_nxt = r_state;
        if (r_acc) begin
            if (!w_dec_ok)
                w_state_nxt = IDLE;
            else if (!w_cat)
                w_state_nxt = HAVE_LO;
            else
                w_state_nxt = IDLE;
        end
    end

    // FSM outputs: which datapath registers load and which strobe fires
    always_comb begin
        w_lo_load    = r_acc && w_dec_ok && !w_cat;
        w_value_load = r_acc && w_dec_ok && w_cat && (r_state == HAVE_LO);
        w_err_nxt    = r_acc && !w_dec_ok;
    end

    // Datapath: low digit holding register, assembled score and the one-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo  <= 4'h0;
            value <= 8'h00;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (w_lo_load)
                r_lo <= w_dec_nib;
            if (w_value_load)
                value <= {w_dec_nib, r_lo};
            valid <= w_value_load;
            err   <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_decode.sv
// tb/tb_ssd_decode.sv - table-driven self-checking bench for ssd_decode
module tb_ssd_decode;

    logic       clk;
    logic       rst_n;
    logic [6:0] ssd;
    logic       ssdcat;
    logic [7:0] value;
    logic       valid;
    logic       err;

    int checks;
    int failures;
    int n_valid;
    int n_err;
    int n_both;

    ssd_decode #(.STABLE_CYCLES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ssd    (ssd),
        .ssdcat (ssdcat),
        .value  (value),
        .valid  (valid),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (valid) n_valid = n_valid + 1;
        if (err)   n_err   = n_err + 1;
        if (valid && err) n_both = n_both + 1;
    end

    typedef struct {
        logic [3:0]      cat;
        logic [3:0][6:0] seg;
        logic [3:0][7:0] hold;
        int              ev;
        int              ee;
        logic [7:0]      evalue;
    } rec_t;

    rec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one pattern from just after a falling edge and hold it for n rising edges
    task automatic drive(input logic cat, input logic [6:0] seg, input int n);
        ssdcat = cat;
        ssd    = seg;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int v0;
        int e0;
        checks   = 0;
        failures = 0;
        n_valid  = 0;
        n_err    = 0;
        n_both   = 0;
        rst_n    = 1'b0;
        ssd      = 7'h00;
        ssdcat   = 1'b0;

        // steps listed right-to-left: index 0 is applied first, hold 0 means unused
        vecs[0]  = '{4'b0010, {7'h00, 7'h00, 7'h30, 7'h5B}, {8'd0, 8'd0, 8'd4, 8'd4}, 1, 0, 8'h15};
        vecs[1]  = '{4'b0100, {7'h00, 7'h47, 7'h79, 7'h7F}, {8'd0, 8'd4, 8'd4, 8'd3}, 1, 0, 8'hF3};
        vecs[2]  = '{4'b0010, {7'h00, 7'h00, 7'h01, 7'h33}, {8'd0, 8'd0, 8'd4, 8'd4}, 0, 1, 8'hF3};
        vecs[3]  = '{4'b0101, {7'h00, 7'h6D, 7'h70, 7'h6D}, {8'd0, 8'd4, 8'd4, 8'd20}, 1, 0, 8'h27};
`ifdef SSD_DECODE_BLANK_EN
        vecs[4]  = '{4'b0010, {7'h00, 7'h00, 7'h00, 7'h4E}, {8'd0, 8'd0, 8'd4, 8'd4}, 1, 0, 8'h0C};
`else
        vecs[4]  = '{4'b0010, {7'h00, 7'h00, 7'h00, 7'h4E}, {8'd0, 8'd0, 8'd4, 8'd4}, 0, 1, 8'h27};
`endif
        vecs[5]  = '{4'b0010, {7'h00, 7'h00, 7'h77, 7'h3D}, {8'd0, 8'd0, 8'd4, 8'd4}, 1, 0, 8'hAD};
        vecs[6]  = '{4'b0010, {7'h00, 7'h00, 7'h4F, 7'h1F}, {8'd0, 8'd0, 8'd4, 8'd4}, 1, 0, 8'hEB};
        vecs[7]  = '{4'b0100, {7'h00, 7'h7E, 7'h73, 7'h30}, {8'd0, 8'd4, 8'd4, 8'd4}, 1, 0, 8'h09};
        vecs[8]  = '{4'b0010, {7'h00, 7'h00, 7'h30, 7'h30}, {8'd0, 8'd0, 8'd4, 8'd4}, 1, 0, 8'h11};
        vecs[9]  = '{4'b0010, {7'h00, 7'h00, 7'h30, 7'h01}, {8'd0, 8'd0, 8'd4, 8'd4}, 0, 1, 8'h11};
        vecs[10] = '{4'b1000, {7'h30, 7'h5B, 7'h7F, 7'h5B}, {8'd4, 8'd3, 8'd1, 8'd2}, 0, 0, 8'h11};
        vecs[11] = '{4'b0010, {7'h00, 7'h00, 7'h5B, 7'h5F}, {8'd0, 8'd0, 8'd4, 8'd4}, 1, 0, 8'h56};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_value", 32'(value), 32'h00);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_err",   32'(err),   32'h0);
        rst_n = 1'b1;
        drive(1'b0, 7'h00, 2);

        // Table of frames
        for (int r = 0; r < 12; r++) begin
            v0 = n_valid;
            e0 = n_err;
            for (int s = 0; s < 4; s++) begin
                if (vecs[r].hold[s] != 8'd0)
                    drive(vecs[r].cat[s], vecs[r].seg[s], int'(vecs[r].hold[s]));
            end
            repeat (2) @(negedge clk);
            #1;
            chk($sformatf("rec%0d_valid_count", r), 32'(n_valid - v0), 32'(vecs[r].ev));
            chk($sformatf("rec%0d_err_count", r),   32'(n_err - e0),   32'(vecs[r].ee));
            chk($sformatf("rec%0d_value", r),       32'(value),        32'(vecs[r].evalue));
        end

        // Latency of the strobe relative to the first sampling edge of the high digit
        drive(1'b0, 7'h7E, 4);
        chk("lat_lo_no_valid", 32'(valid), 32'h0);
        ssdcat = 1'b1;
        ssd    = 7'h30;
        repeat (4) @(negedge clk);
        #1;
        chk("lat_accept_edge_no_valid", 32'(valid), 32'h0);
        @(negedge clk);
        #1;
        chk("lat_valid_pulse", 32'(valid), 32'h1);
        chk("lat_value",       32'(value), 32'h10);
        @(negedge clk);
        #1;
        chk("lat_valid_one_cycle", 32'(valid), 32'h0);

        // Reset mid-frame discards the pending low digit
        drive(1'b0, 7'h73, 6);
        rst_n = 1'b0;
        #1;
        chk("midrst_value", 32'(value), 32'h00);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_err",   32'(err),   32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        v0 = n_valid;
        drive(1'b1, 7'h30, 6);
        chk("midrst_no_valid", 32'(n_valid - v0), 32'h0);
        chk("midrst_value_after", 32'(value), 32'h00);

        chk("valid_err_exclusive", 32'(n_both), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
